// File: rtl/or4_chk_pkg.sv
// ---------------------------------------------------------------------------
// or4_chk_pkg
// Shared definitions for the four-input OR response checker.
//   state_t     : checker phase (IDLE, RUN, PASS, FAIL)
//   N_CODES     : number of distinct 4-bit stimulus codes to cover
//   or4_golden  : expected {g,f,e} for a stimulus {d,c,b,a}
// ---------------------------------------------------------------------------
package or4_chk_pkg;

  localparam int N_CODES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  // Two-level OR: f covers {b,a}, g covers {d,c}, e combines both.
  function automatic logic [2:0] or4_golden(input logic [3:0] stim);
    logic w_f;
    logic w_g;
    w_f = stim[0] | stim[1];
    w_g = stim[2] | stim[3];
    return {w_g, w_f, w_f | w_g};
  endfunction

endpackage

// File: rtl/or4_response_checker_if.sv
// ---------------------------------------------------------------------------
// or4_response_checker_if
// Bundles the checker's control, sample and result signals.
//   start      : one-cycle pulse that begins a check run
//   in_valid   : stim/obs valid this cycle
//   stim       : {d,c,b,a} applied to the OR gate under test
//   obs        : {g,f,e} observed from the OR gate under test
//   busy/pass/fail/timeout : run status
//   err_cnt    : saturating mismatch count (ERR_W bits)
//   cov_map    : bit k set once stim==k has been sampled
//   fail_stim/fail_obs : first failing vector of the run
// master drives stimulus and reads results; slave is the checker.
// ---------------------------------------------------------------------------
interface or4_response_checker_if #(
  parameter int ERR_W = 8
);
  logic                              start;
  logic                              in_valid;
  logic [3:0]                        stim;
  logic [2:0]                        obs;
  logic                              busy;
  logic                              pass;
  logic                              fail;
  logic                              timeout;
  logic [ERR_W-1:0]                  err_cnt;
  logic [or4_chk_pkg::N_CODES-1:0]   cov_map;
  logic [3:0]                        fail_stim;
  logic [2:0]                        fail_obs;

  modport master (
    output start, in_valid, stim, obs,
    input  busy, pass, fail, timeout, err_cnt, cov_map, fail_stim, fail_obs
  );

  modport slave (
    input  start, in_valid, stim, obs,
    output busy, pass, fail, timeout, err_cnt, cov_map, fail_stim, fail_obs
  );
endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset to zero
//   i_clr : synchronous clear (wins over i_inc)
//   i_inc : increment request
//   o_cnt : current count (W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/or4_response_checker.sv
// ---------------------------------------------------------------------------
// or4_response_checker
// Compares observed OR-gate outputs against the golden two-level OR
// function, tracks coverage of all 16 input codes, and reports PASS/FAIL,
// including a timeout failure and the first failing vector.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   io_bus : or4_response_checker_if.slave (start, samples, results)
// Parameters:
//   TIMEOUT_CYC  : RUN cycles allowed before a timeout failure (1..65535)
//   ERR_W        : width of the saturating mismatch counter
//   STOP_ON_FAIL : 1 = end the run on the first mismatch
// ---------------------------------------------------------------------------
module or4_response_checker
  import or4_chk_pkg::*;
#(
  parameter int TIMEOUT_CYC  = 1024,
  parameter int ERR_W        = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  or4_response_checker_if.slave io_bus
);

  localparam int          TMO_W    = 16;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_CODES-1:0]   r_cov_map;
  logic [3:0]           r_fail_stim;
  logic [2:0]           r_fail_obs;
  logic                 r_timeout;

  logic [ERR_W-1:0]     w_err;
  logic [TMO_W-1:0]     w_cyc;
  logic [2:0]           w_gold;
  logic                 w_mis;
  logic                 w_cov_full;
  logic                 w_clr;
  logic                 w_accept;
  logic                 w_cyc_inc;
  logic                 w_tmo_set;

  assign w_gold     = or4_golden(io_bus.stim);
  assign w_mis      = (io_bus.obs != w_gold);
  assign w_cov_full = &r_cov_map;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Exits are judged on the already-registered results, so a sample's effect
  // shows up in the state one edge after it lands in cov_map/err_cnt. On the
  // exit edge itself no new sample is taken, which keeps the reported results
  // exactly those that caused the exit.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_accept    = 1'b0;
    w_cyc_inc   = 1'b0;
    w_tmo_set   = 1'b0;
    case (r_state)
      RUN: begin
        if (STOP_ON_FAIL && (w_err != '0)) begin
          w_state_nxt = FAIL;
        end else if (w_cov_full) begin
          w_state_nxt = (w_err == '0) ? PASS : FAIL;
        end else if (w_cyc == TMO_LAST) begin
          w_state_nxt = FAIL;
          w_tmo_set   = 1'b1;
        end else begin
          w_cyc_inc = 1'b1;
          w_accept  = io_bus.in_valid;
        end
      end
      IDLE, PASS, FAIL: begin
        if (io_bus.start) begin
          w_state_nxt = RUN;
          w_clr       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_inc (w_accept && w_mis),
    .o_cnt (w_err)
  );

  sat_counter #(.W(TMO_W)) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_inc (w_cyc_inc),
    .o_cnt (w_cyc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cov_map <= '0;
    end else if (w_clr) begin
      r_cov_map <= '0;
    end else if (w_accept) begin
      r_cov_map[io_bus.stim] <= 1'b1;
    end
  end

  // The counter never returns to zero within a run (it saturates), so a zero
  // count identifies the first mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_stim <= '0;
      r_fail_obs  <= '0;
    end else if (w_clr) begin
      r_fail_stim <= '0;
      r_fail_obs  <= '0;
    end else if (w_accept && w_mis && (w_err == '0)) begin
      r_fail_stim <= io_bus.stim;
      r_fail_obs  <= io_bus.obs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_clr) begin
      r_timeout <= 1'b0;
    end else if (w_tmo_set) begin
      r_timeout <= 1'b1;
    end
  end

  assign io_bus.busy      = (r_state == RUN);
  assign io_bus.pass      = (r_state == PASS);
  assign io_bus.fail      = (r_state == FAIL);
  assign io_bus.timeout   = r_timeout;
  assign io_bus.err_cnt   = w_err;
  assign io_bus.cov_map   = r_cov_map;
  assign io_bus.fail_stim = r_fail_stim;
  assign io_bus.fail_obs  = r_fail_obs;

endmodule

// File: tb/tb_or4_response_checker.sv
// ---------------------------------------------------------------------------
// tb_or4_response_checker
// Four checker instances share one stimulus stream:
//   d0 : defaults (TIMEOUT_CYC=1024, ERR_W=8, STOP_ON_FAIL=0)
//   d1 : STOP_ON_FAIL=1
//   d2 : TIMEOUT_CYC=20
//   d3 : ERR_W=2
// The OR gate under test is emulated by 'fault': 0 correct, 1 e stuck-at-0,
// 2 every output inverted. A behavioural model of each checker is compared
// against all outputs every cycle; directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_or4_response_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] stim = 4'd0;
  logic [2:0] obs;
  int         fault = 0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_obs(input logic [3:0] s);
    return {(s[3] | s[2]), (s[1] | s[0]), (s != 4'd0)};
  endfunction

  always_comb begin
    obs = exp_obs(stim);
    if (fault == 1) obs[0] = 1'b0;
    else if (fault == 2) obs = ~exp_obs(stim);
  end

  or4_response_checker_if #(.ERR_W(8)) if0 ();
  or4_response_checker_if #(.ERR_W(8)) if1 ();
  or4_response_checker_if #(.ERR_W(8)) if2 ();
  or4_response_checker_if #(.ERR_W(2)) if3 ();

  assign if0.start = start; assign if0.in_valid = in_valid; assign if0.stim = stim; assign if0.obs = obs;
  assign if1.start = start; assign if1.in_valid = in_valid; assign if1.stim = stim; assign if1.obs = obs;
  assign if2.start = start; assign if2.in_valid = in_valid; assign if2.stim = stim; assign if2.obs = obs;
  assign if3.start = start; assign if3.in_valid = in_valid; assign if3.stim = stim; assign if3.obs = obs;

  or4_response_checker #(.TIMEOUT_CYC(1024), .ERR_W(8), .STOP_ON_FAIL(1'b0)) d0 (.clk(clk), .rst(rst), .io_bus(if0));
  or4_response_checker #(.TIMEOUT_CYC(1024), .ERR_W(8), .STOP_ON_FAIL(1'b1)) d1 (.clk(clk), .rst(rst), .io_bus(if1));
  or4_response_checker #(.TIMEOUT_CYC(20),   .ERR_W(8), .STOP_ON_FAIL(1'b0)) d2 (.clk(clk), .rst(rst), .io_bus(if2));
  or4_response_checker #(.TIMEOUT_CYC(1024), .ERR_W(2), .STOP_ON_FAIL(1'b0)) d3 (.clk(clk), .rst(rst), .io_bus(if3));

  // Gathered DUT outputs, indexed by instance.
  logic        a_busy [4];
  logic        a_pass [4];
  logic        a_fail [4];
  logic        a_to   [4];
  logic [7:0]  a_err  [4];
  logic [15:0] a_cov  [4];
  logic [3:0]  a_fs   [4];
  logic [2:0]  a_fo   [4];

  assign a_busy[0] = if0.busy; assign a_pass[0] = if0.pass; assign a_fail[0] = if0.fail; assign a_to[0] = if0.timeout;
  assign a_busy[1] = if1.busy; assign a_pass[1] = if1.pass; assign a_fail[1] = if1.fail; assign a_to[1] = if1.timeout;
  assign a_busy[2] = if2.busy; assign a_pass[2] = if2.pass; assign a_fail[2] = if2.fail; assign a_to[2] = if2.timeout;
  assign a_busy[3] = if3.busy; assign a_pass[3] = if3.pass; assign a_fail[3] = if3.fail; assign a_to[3] = if3.timeout;
  assign a_err[0] = if0.err_cnt; assign a_err[1] = if1.err_cnt; assign a_err[2] = if2.err_cnt;
  assign a_err[3] = {6'd0, if3.err_cnt};
  assign a_cov[0] = if0.cov_map; assign a_cov[1] = if1.cov_map; assign a_cov[2] = if2.cov_map; assign a_cov[3] = if3.cov_map;
  assign a_fs[0] = if0.fail_stim; assign a_fs[1] = if1.fail_stim; assign a_fs[2] = if2.fail_stim; assign a_fs[3] = if3.fail_stim;
  assign a_fo[0] = if0.fail_obs;  assign a_fo[1] = if1.fail_obs;  assign a_fo[2] = if2.fail_obs;  assign a_fo[3] = if3.fail_obs;

  // Per-instance parameters seen by the model.
  int p_tmo    [4] = '{1024, 1024, 20, 1024};
  int p_errmax [4] = '{255, 255, 255, 3};
  bit p_sof    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  // Model: phase 0 idle, 1 running, 2 passed, 3 failed.
  int        m_phase [4];
  bit [15:0] m_cov   [4];
  int        m_err   [4];
  int        m_cyc   [4];
  bit        m_to    [4];
  bit [3:0]  m_fs    [4];
  bit [2:0]  m_fo    [4];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_phase[i] = 0; m_cov[i] = '0; m_err[i] = 0; m_cyc[i] = 0;
        m_to[i] = 1'b0; m_fs[i] = '0; m_fo[i] = '0;
      end else if (m_phase[i] == 1) begin
        if (p_sof[i] && m_err[i] != 0) begin
          m_phase[i] = 3;
        end else if (m_cov[i] == 16'hFFFF) begin
          m_phase[i] = (m_err[i] == 0) ? 2 : 3;
        end else if (m_cyc[i] == p_tmo[i] - 1) begin
          m_phase[i] = 3;
          m_to[i]    = 1'b1;
        end else begin
          m_cyc[i] = m_cyc[i] + 1;
          if (in_valid) begin
            m_cov[i][stim] = 1'b1;
            if (obs != exp_obs(stim)) begin
              if (m_err[i] == 0) begin
                m_fs[i] = stim;
                m_fo[i] = obs;
              end
              if (m_err[i] < p_errmax[i]) m_err[i] = m_err[i] + 1;
            end
          end
        end
      end else if (start) begin
        m_phase[i] = 1; m_cov[i] = '0; m_err[i] = 0; m_cyc[i] = 0;
        m_to[i] = 1'b0; m_fs[i] = '0; m_fo[i] = '0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d%0d.busy", i),      32'(a_busy[i]), 32'(m_phase[i] == 1));
      chk($sformatf("d%0d.pass", i),      32'(a_pass[i]), 32'(m_phase[i] == 2));
      chk($sformatf("d%0d.fail", i),      32'(a_fail[i]), 32'(m_phase[i] == 3));
      chk($sformatf("d%0d.timeout", i),   32'(a_to[i]),   32'(m_to[i]));
      chk($sformatf("d%0d.err_cnt", i),   32'(a_err[i]),  32'(m_err[i]));
      chk($sformatf("d%0d.cov_map", i),   32'(a_cov[i]),  32'(m_cov[i]));
      chk($sformatf("d%0d.fail_stim", i), 32'(a_fs[i]),   32'(m_fs[i]));
      chk($sformatf("d%0d.fail_obs", i),  32'(a_fo[i]),   32'(m_fo[i]));
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick(2);
    chk("rst.busy",  32'(a_busy[0]), 32'd0);
    chk("rst.pass",  32'(a_pass[0]), 32'd0);
    chk("rst.fail",  32'(a_fail[0]), 32'd0);
    chk("rst.cov",   32'(a_cov[0]),  32'd0);
    chk("rst.err",   32'(a_err[0]),  32'd0);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // One sample per cycle; 'restart_at' raises start alongside that sample.
  task automatic sweep(input int lo, input int hi, input int restart_at);
    for (int k = lo; k <= hi; k++) begin
      in_valid = 1'b1;
      stim     = 4'(k);
      start    = (k == restart_at);
      tick(1);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    // Reset state.
    do_reset();

    // Correct gate, full sweep; a start mid-run and a pre-start sample are ignored.
    fault = 0;
    in_valid = 1'b1; stim = 4'd5;
    tick(1);
    in_valid = 1'b0;
    chk("idle.cov_ignored", 32'(a_cov[0]), 32'd0);
    pulse_start();
    sweep(0, 15, 8);
    chk("t1.pass_early", 32'(a_pass[0]), 32'd0);
    chk("t1.busy_early", 32'(a_busy[0]), 32'd1);
    tick(1);
    chk("t1.pass", 32'(a_pass[0]), 32'd1);
    chk("t1.fail", 32'(a_fail[0]), 32'd0);
    chk("t1.err",  32'(a_err[0]),  32'd0);
    chk("t1.cov",  32'(a_cov[0]),  32'hFFFF);

    // e stuck-at-0, restarted straight from PASS.
    fault = 1;
    pulse_start();
    for (int k = 0; k <= 15; k++) begin
      in_valid = 1'b1;
      stim     = 4'(k);
      tick(1);
      if (k == 1) chk("t3.d1_fail_not_yet", 32'(a_fail[1]), 32'd0);
      if (k == 2) chk("t3.d1_fail_2cyc",    32'(a_fail[1]), 32'd1);
    end
    in_valid = 1'b0;
    tick(1);
    chk("t2.fail",      32'(a_fail[0]), 32'd1);
    chk("t2.err",       32'(a_err[0]),  32'd15);
    chk("t2.fail_stim", 32'(a_fs[0]),   32'h1);
    chk("t2.fail_obs",  32'(a_fo[0]),   32'b010);
    chk("t2.timeout",   32'(a_to[0]),   32'd0);
    chk("t3.err",       32'(a_err[1]),  32'd1);
    chk("t3.cov",       32'(a_cov[1]),  32'h0003);

    // Timeout: only codes 0..7 (sent twice), d2 allows 20 RUN cycles.
    do_reset();
    fault = 0;
    pulse_start();
    sweep(0, 7, -1);
    sweep(0, 7, -1);
    tick(3);
    chk("t4.busy_19", 32'(a_busy[2]), 32'd1);
    chk("t4.fail_19", 32'(a_fail[2]), 32'd0);
    tick(1);
    chk("t4.fail",    32'(a_fail[2]), 32'd1);
    chk("t4.timeout", 32'(a_to[2]),   32'd1);
    chk("t4.cov",     32'(a_cov[2]),  32'h00FF);
    chk("t4.err",     32'(a_err[2]),  32'd0);

    // Always-wrong gate: saturation at 3 for ERR_W=2.
    do_reset();
    fault = 2;
    pulse_start();
    sweep(0, 15, -1);
    tick(1);
    chk("t5.err_sat",   32'(a_err[3]),  32'd3);
    chk("t5.fail",      32'(a_fail[3]), 32'd1);
    chk("t5.d0_err",    32'(a_err[0]),  32'd16);
    chk("t5.fail_obs",  32'(a_fo[0]),   32'b111);

    // Reset mid-run, then a fresh full run.
    do_reset();
    fault = 0;
    pulse_start();
    sweep(0, 4, -1);
    chk("t6.cov_partial", 32'(a_cov[0]), 32'h001F);
    do_reset();
    tick(1);
    chk("t6.cov_after_rst", 32'(a_cov[0]), 32'd0);
    pulse_start();
    sweep(0, 15, -1);
    tick(1);
    chk("t6.pass", 32'(a_pass[0]), 32'd1);
    chk("t6.cov",  32'(a_cov[0]),  32'hFFFF);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/or4_response_checker.md
Name: or4_response_checker

Overview:
- Synthesizable checker at the response end of the four-input OR stimulus interface.
- Samples stimulus (a..d) and the DUT's outputs (e,f,g), compares them against the golden two-level OR function, and records coverage of all 16 input codes.
- Reports PASS/FAIL and captures the first failing vector.
- Lets the board-level lab build run the OR-gate test without a simulator.

Parameters:
- TIMEOUT_CYC, 1024: maximum clocks in RUN before declaring timeout failure; range 1..2^16-1.
- ERR_W, 8: width of the mismatch counter; the counter saturates.
- STOP_ON_FAIL, 0: 1 = go to FAIL on the first mismatch; 0 = keep checking until full coverage or timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a check run from IDLE or from a finished state
- in_valid  in  1  stim/obs are valid this cycle
- stim  in  4  {d,c,b,a} applied to the DUT
- obs  in  3  {g,f,e} observed from the DUT
- busy  out  1  high in RUN
- pass  out  1  high in PASS
- fail  out  1  high in FAIL
- timeout  out  1  set when FAIL was entered by timeout
- err_cnt  out  ERR_W  saturating count of mismatching samples
- cov_map  out  16  bit k set once stim==k has been sampled
- fail_stim  out  4  stim of the first mismatch
- fail_obs  out  3  obs of the first mismatch

Behaviour:
- Golden function:
  - f_exp = a|b
  - g_exp = c|d
  - e_exp = f_exp|g_exp
  - Mismatch = obs != {g_exp,f_exp,e_exp}.
- Reset (asynchronous): state=IDLE.
  - All outputs 0; cov_map=0; err_cnt=0; fail_stim=0; fail_obs=0; timeout cycle counter=0.
- States: IDLE, RUN, PASS, FAIL. Outputs are registered and decoded from state.
- Transitions:
  - IDLE: start -> RUN; clear cov_map, err_cnt, fail_*, timeout and the cycle counter.
  - RUN, per in_valid sample at edge N:
    - cov_map[stim] set at edge N.
    - On mismatch: err_cnt incremented at edge N.
    - On the first mismatch of the run: fail_stim/fail_obs captured at edge N.
  - RUN exits (evaluated on the updated values, visible after edge N+1):
    - STOP_ON_FAIL=1 and err_cnt became nonzero -> FAIL.
    - cov_map all ones and err_cnt==0 -> PASS.
    - cov_map all ones and err_cnt!=0 -> FAIL.
    - Cycle counter reaches TIMEOUT_CYC-1 without one of the above -> FAIL with timeout=1.
  - Priority in RUN: mismatch-fail > coverage completion > timeout.
  - PASS/FAIL: hold all results; start -> RUN, with the same clearing as from IDLE.
- Latency: the sample's effect on cov_map/err_cnt is visible 1 cycle after the sampling edge; pass/fail asserts 2 cycles after the completing sample.
- in_valid outside RUN is ignored; no counters change.
- start while in RUN is ignored; the run continues.
- err_cnt saturates at 2^ERR_W-1 and never wraps.
- Repeated stim codes are legal; they are re-checked but add no new coverage.
- rst mid-RUN: immediate return to the reset values above; no partial results are retained.
- The cycle counter increments every RUN cycle regardless of in_valid.

Decomposition:
- Shared package or4_chk_pkg:
  - State enum {IDLE,RUN,PASS,FAIL}.
  - Function or4_golden(stim) -> 3-bit expected {g,f,e}.
  - Constant N_CODES=16.
- One natural sub-module, sat_counter (parameterized width, inc, clr, saturating). Used for err_cnt and, with its own width, for the timeout counter.

Test Plan:
- Correct DUT model, stim counting 0..15 with in_valid=1 each cycle after start: pass=1 two cycles after stim=15; err_cnt=0; cov_map=16'hFFFF; fail=0.
- Faulty DUT with e stuck-at-0, STOP_ON_FAIL=0, sweep 0..15: fail=1; err_cnt=15; fail_stim=4'h1; fail_obs=3'b010.
- Same fault with STOP_ON_FAIL=1: fail asserts 2 cycles after the stim=1 sample; err_cnt=1; cov_map=16'h0003.
- TIMEOUT_CYC=20, only codes 0..7 sent: fail=1 and timeout=1 after 20 RUN cycles; cov_map=16'h00FF; err_cnt=0.
- ERR_W=2 with an always-wrong DUT and 16 samples: err_cnt holds at 3.
- rst pulsed after 5 samples, then start and a full sweep: all outputs 0 during reset; cov_map=0 after reset; the later run reaches pass=1.
